// File: rtl/alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// alu_cmd_driver
//   Initiator side of the ALU wr/done handshake. It takes one command from a
//   valid/ready command port and drives opcode/opa/opb/wr into the ALU. It then
//   waits for done to go low and come back high, captures res/status, and
//   returns them on a valid/ready response port. A watchdog aborts either wait
//   phase after TIMEOUT_CYCLES cycles. Only one operation is in flight at a
//   time.
//
// Ports
//   clk, rstn                    clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_opcode/cmd_opa/cmd_opb   command payload
//   opcode/opa/opb/wr            ALU request side
//   done/status/res              ALU completion side
//   rsp_valid/rsp_ready          response handshake
//   rsp_res/rsp_status           captured ALU result and status
//   rsp_timeout                  1 = aborted by the watchdog (rsp_res = 0)
//   op_count                     number of accepted non-timeout responses
// ---------------------------------------------------------------------------
module alu_cmd_driver #(
    parameter int OPCODE_WIDTH   = 2,
    parameter int DATA_WIDTH     = 9,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [OPCODE_WIDTH-1:0] cmd_opcode,
    input  logic [DATA_WIDTH-1:0]   cmd_opa,
    input  logic [DATA_WIDTH-1:0]   cmd_opb,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic [DATA_WIDTH-1:0]   opa,
    output logic [DATA_WIDTH-1:0]   opb,
    output logic                    wr,
    input  logic                    done,
    input  logic                    status,
    input  logic [DATA_WIDTH-1:0]   res,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_res,
    output logic                    rsp_status,
    output logic                    rsp_timeout,
    output logic [CNT_WIDTH-1:0]    op_count
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOW  = 2'd1,
        WAIT_HIGH = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
    logic [DATA_WIDTH-1:0]   opa_q, opa_d;
    logic [DATA_WIDTH-1:0]   opb_q, opb_d;
    logic                    wr_q, wr_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_res_q, rsp_res_d;
    logic                    rsp_status_q, rsp_status_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic [CNT_WIDTH-1:0]    op_count_q, op_count_d;
    logic [TW-1:0]           timer_q, timer_d;

    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        wr_d          = wr_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_res_d     = rsp_res_q;
        rsp_status_d  = rsp_status_q;
        rsp_timeout_d = rsp_timeout_q;
        op_count_d    = op_count_q;
        timer_d       = timer_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    opcode_d = cmd_opcode;
                    opa_d    = cmd_opa;
                    opb_d    = cmd_opb;
                    wr_d     = 1'b1;
                    timer_d  = '0;
                    state_d  = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                // Exit condition is tested first so it wins over the watchdog.
                if (!done) begin
                    wr_d    = 1'b0;
                    timer_d = '0;
                    state_d = WAIT_HIGH;
                end else if (timer_q == TIMER_LAST) begin
                    wr_d          = 1'b0;
                    rsp_res_d     = '0;
                    rsp_status_d  = 1'b0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    timer_d       = '0;
                    state_d       = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WAIT_HIGH: begin
                if (done) begin
                    rsp_res_d     = res;
                    rsp_status_d  = status;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    timer_d       = '0;
                    state_d       = RESP;
                end else if (timer_q == TIMER_LAST) begin
                    rsp_res_d     = '0;
                    rsp_status_d  = 1'b0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    timer_d       = '0;
                    state_d       = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!rsp_timeout_q) begin
                        op_count_d = op_count_q + CNT_WIDTH'(1);
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered so cmd_ready stays low through reset and rises one cycle
        // after release.
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            opcode_q      <= '0;
            opa_q         <= '0;
            opb_q         <= '0;
            wr_q          <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_res_q     <= '0;
            rsp_status_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
            op_count_q    <= '0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            opcode_q      <= opcode_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            wr_q          <= wr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_res_q     <= rsp_res_d;
            rsp_status_q  <= rsp_status_d;
            rsp_timeout_q <= rsp_timeout_d;
            op_count_q    <= op_count_d;
            timer_q       <= timer_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign opcode      = opcode_q;
    assign opa         = opa_q;
    assign opb         = opb_q;
    assign wr          = wr_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_res     = rsp_res_q;
    assign rsp_status  = rsp_status_q;
    assign rsp_timeout = rsp_timeout_q;
    assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_driver
//   Directed bench for alu_cmd_driver with a small behavioural ALU responder.
//   All stimulus is driven, and all outputs are sampled, 1 time unit after a
//   rising clock edge.
// ---------------------------------------------------------------------------
module tb_alu_cmd_driver;

    localparam int OW = 2;
    localparam int DW = 9;
    localparam int TO = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [OW-1:0] cmd_opcode;
    logic [DW-1:0] cmd_opa;
    logic [DW-1:0] cmd_opb;
    logic [OW-1:0] opcode;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic          wr;
    logic          done;
    logic          status;
    logic [DW-1:0] res;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_res;
    logic          rsp_status;
    logic          rsp_timeout;
    logic [CW-1:0] op_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_cmd_driver #(
        .OPCODE_WIDTH  (OW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_opa    (cmd_opa),
        .cmd_opb    (cmd_opb),
        .opcode     (opcode),
        .opa        (opa),
        .opb        (opb),
        .wr         (wr),
        .done       (done),
        .status     (status),
        .res        (res),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_res    (rsp_res),
        .rsp_status (rsp_status),
        .rsp_timeout(rsp_timeout),
        .op_count   (op_count)
    );

    // ALU responder. Mode 0: seeing wr with done high, drop done on that
    // edge, then raise it with the result three cycles later.
    // 00 add, 01 sub, 10 shift right by opb, 11 shift left by opb.
    // Mode 1: done stuck high, wr ignored.
    logic       alu_stuck = 1'b0;
    logic       alu_busy;
    logic [1:0] alu_cnt;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done     <= 1'b1;
            status   <= 1'b0;
            res      <= '0;
            alu_busy <= 1'b0;
            alu_cnt  <= 2'd0;
        end else if (!alu_stuck) begin
            if (alu_busy) begin
                if (alu_cnt == 2'd2) begin
                    done     <= 1'b1;
                    status   <= 1'b1;
                    alu_busy <= 1'b0;
                    case (opcode)
                        2'b00:   res <= opa + opb;
                        2'b01:   res <= opa - opb;
                        2'b10:   res <= opa >> opb;
                        default: res <= opa << opb;
                    endcase
                end else begin
                    alu_cnt <= alu_cnt + 2'd1;
                end
            end else if (wr && done) begin
                done     <= 1'b0;
                alu_busy <= 1'b1;
                alu_cnt  <= 2'd0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, wait for the response, hold it for 'hold' cycles of
    // backpressure (checking stability), then complete the handshake.
    task automatic run_op(input logic [OW-1:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input int hold,
                          output logic [DW-1:0] r, output logic s, output logic t,
                          output int wr_cycles, output int latency);
        int n;
        logic [CW-1:0] cnt_before;
        n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_opa    = a;
        cmd_opb    = b;
        step();
        cmd_valid  = 1'b0;
        n          = 0;
        wr_cycles  = 0;
        while (!rsp_valid && n < 100) begin
            if (wr) wr_cycles++;
            step();
            n++;
        end
        latency = n;
        chk("rsp_valid_wait", {31'd0, rsp_valid}, 32'd1);
        r = rsp_res;
        s = rsp_status;
        t = rsp_timeout;
        cnt_before = op_count;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_res", {23'd0, rsp_res}, {23'd0, r});
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("bp_op_count", {16'd0, op_count}, {16'd0, cnt_before});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
        $display("op=%0d opa=%0d opb=%0d -> res=%0d status=%0d timeout=%0d wr_cycles=%0d latency=%0d op_count=%0d",
                 op, a, b, r, s, t, wr_cycles, latency, op_count);
    endtask

    initial begin
        logic [DW-1:0] r;
        logic          s;
        logic          t;
        int            wc;
        int            lat;
        int            n;
        logic [1:0]    b2b_op  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [DW-1:0] b2b_exp [4] = '{9'd203, 9'd197, 9'd25, 9'd64};

        rstn       = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_opa    = '0;
        cmd_opb    = '0;
        rsp_ready  = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_wr", {31'd0, wr}, 32'd0);
        chk("rst_opcode", {30'd0, opcode}, 32'd0);
        chk("rst_opa", {23'd0, opa}, 32'd0);
        chk("rst_opb", {23'd0, opb}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_res", {23'd0, rsp_res}, 32'd0);
        chk("rst_rsp_status", {31'd0, rsp_status}, 32'd0);
        chk("rst_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        chk("rst_op_count", {16'd0, op_count}, 32'd0);
        rstn = 1'b1;
        chk("release_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        step();
        chk("release_cmd_ready_high", {31'd0, cmd_ready}, 32'd1);

        // Single ADD: 5 + 7
        run_op(2'b00, 9'd5, 9'd7, 0, r, s, t, wc, lat);
        chk("add_wr_cycles", wc, 32'd2);
        chk("add_latency", lat, 32'd5);
        chk("add_res", {23'd0, r}, 32'd12);
        chk("add_status", {31'd0, s}, 32'd1);
        chk("add_timeout", {31'd0, t}, 32'd0);
        chk("add_op_count", {16'd0, op_count}, 32'd1);

        // Same op with 5 cycles of backpressure
        run_op(2'b00, 9'd5, 9'd7, 5, r, s, t, wc, lat);
        chk("bp_res", {23'd0, r}, 32'd12);
        chk("bp_op_count_after", {16'd0, op_count}, 32'd2);

        // Timeout: done stuck high, watchdog fires in WAIT_LOW
        alu_stuck = 1'b1;
        run_op(2'b01, 9'd9, 9'd4, 0, r, s, t, wc, lat);
        chk("to_wr_cycles", wc, 32'd8);
        chk("to_latency", lat, 32'd8);
        chk("to_timeout", {31'd0, t}, 32'd1);
        chk("to_res", {23'd0, r}, 32'd0);
        chk("to_status", {31'd0, s}, 32'd0);
        chk("to_wr_low", {31'd0, wr}, 32'd0);
        chk("to_op_count", {16'd0, op_count}, 32'd2);
        alu_stuck = 1'b0;

        // Back-to-back: opa=200, opb=3 with all four opcodes
        for (int k = 0; k < 4; k++) begin
            run_op(b2b_op[k], 9'd200, 9'd3, 0, r, s, t, wc, lat);
            chk("b2b_res", {23'd0, r}, {23'd0, b2b_exp[k]});
            chk("b2b_timeout", {31'd0, t}, 32'd0);
        end
        chk("b2b_op_count", {16'd0, op_count}, 32'd6);

        // Async reset while in WAIT_HIGH
        n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        cmd_valid  = 1'b1;
        cmd_opcode = 2'b00;
        cmd_opa    = 9'd1;
        cmd_opb    = 9'd2;
        step();
        cmd_valid  = 1'b0;
        chk("ar_wr_high", {31'd0, wr}, 32'd1);
        n = 0;
        while (wr && n < 50) begin
            step();
            n++;
        end
        step();
        chk("ar_waiting", {31'd0, rsp_valid}, 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_wr", {31'd0, wr}, 32'd0);
        chk("ar_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("ar_op_count", {16'd0, op_count}, 32'd0);
        chk("ar_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        step();
        step();
        rstn = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rsp_valid) n++;
        end
        chk("ar_no_response", n, 32'd0);
        chk("ar_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
        chk("ar_op_count_after", {16'd0, op_count}, 32'd0);
        $display("async reset in WAIT_HIGH: rsp_valid cycles after release=%0d op_count=%0d", n, op_count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
